pc_fetch_sequencer: RTL and testbench

//  Holds the program counter and consumes the redirect target produced by the branch/jump

---
 rtl/riscv_fetch_pkg.sv | 19 +
 rtl/pc_next_sel.sv | 29 ++
 rtl/pc_fetch_sequencer.sv | 106 ++++++++++
 tb/tb_pc_fetch_sequencer.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_fetch_pkg.sv
// Shared fetch-stage types and constants: FSM state encoding, PC step, default reset vector.
package riscv_fetch_pkg;

    localparam logic [31:0] PC_INC            = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2,
        DRAIN    = 2'd3
    } fetch_state_t;

    // Instruction fetch targets must be word aligned.
    function automatic logic is_word_aligned(input logic [1:0] lsb);
        return lsb == 2'b00;
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC select: an aligned redirect wins, otherwise step past a consumed fetch, otherwise hold.
module pc_next_sel
    import riscv_fetch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic            advance,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic [XLEN-1:0] pc_next,
    output logic            redirect_take,
    output logic            redirect_misalign
);

    logic aligned;

    always_comb begin
        aligned           = is_word_aligned(redirect_target[1:0]);
        redirect_take     = redirect_valid && aligned;
        redirect_misalign = redirect_valid && !aligned;
        pc_next           = pc;
        if (redirect_take)
            pc_next = redirect_target;
        else if (advance)
            pc_next = pc + XLEN'(PC_INC);   // natural wrap at the top of the address space
    end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Front-end fetch sequencer: owns the PC, issues one imem read at a time and hands
// fetched words with their PC to decode through a single stall-able holding register.
module pc_fetch_sequencer
    import riscv_fetch_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = DEFAULT_RESET_VEC
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            stall,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc,
    output logic            misalign_exc,
    output logic [XLEN-1:0] misalign_addr
);

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_req;
    logic [XLEN-1:0] pc_next;
    logic            hold_inst;
    logic            req_fire;
    logic            rsp_in_wait;
    logic            redirect_take;
    logic            redirect_misalign;

    // A held, unconsumed instruction blocks new requests so a response always has room.
    assign hold_inst      = inst_valid && stall;
    assign imem_req_valid = (state == REQ) && !hold_inst;
    assign imem_req_addr  = imem_req_valid ? pc : '0;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_in_wait    = (state == WAIT_RSP) && imem_rsp_valid;

    pc_next_sel #(
        .XLEN (XLEN)
    ) u_pc_next_sel (
        .pc                (pc),
        .advance           (rsp_in_wait),
        .redirect_valid    (redirect_valid),
        .redirect_target   (redirect_target),
        .pc_next           (pc_next),
        .redirect_take     (redirect_take),
        .redirect_misalign (redirect_misalign)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= BOOT;
            pc            <= RESET_VEC;
            pc_req        <= '0;
            inst_valid    <= 1'b0;
            inst_data     <= '0;
            inst_pc       <= '0;
            misalign_exc  <= 1'b0;
            misalign_addr <= '0;
        end else begin
            pc           <= pc_next;
            misalign_exc <= redirect_misalign;
            if (redirect_misalign)
                misalign_addr <= redirect_target;

            // Holding register: flush beats load beats consume.
            if (redirect_take) begin
                inst_valid <= 1'b0;
            end else if (rsp_in_wait) begin
                inst_valid <= 1'b1;
                inst_data  <= imem_rsp_data;
                inst_pc    <= pc_req;
            end else if (inst_valid && !stall) begin
                inst_valid <= 1'b0;
            end

            case (state)
                BOOT: state <= REQ;
                REQ: begin
                    if (req_fire) begin
                        pc_req <= pc;
                        state  <= redirect_take ? DRAIN : WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    // A response racing a redirect is simply dropped by the flush above.
                    if (imem_rsp_valid)
                        state <= REQ;
                    else if (redirect_take)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (imem_rsp_valid)
                        state <= REQ;
                end
                default: state <= BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Scoreboard bench for pc_fetch_sequencer: a latency-configurable imem model pushes the
// expected {pc,data} of every response that should survive; consumed instructions pop it.
module tb_pc_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        stall = 1'b0;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;

    logic        imem_req_valid, inst_valid, misalign_exc;
    logic [31:0] imem_req_addr, inst_data, inst_pc, misalign_addr;
    logic        req_valid1, inst_valid1, mexc1;
    logic [31:0] req_addr1, inst_data1, inst_pc1, maddr1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] acc_log[$];
    logic [31:0] acc_log1[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          n_pop = 0;
    int          mem_lat = 1;
    int          drop_cnt = 0;
    int          pend_cnt = 0;
    bit          pend = 1'b0;
    logic [31:0] pend_addr = '0;

    always #5 clk = ~clk;

    pc_fetch_sequencer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .stall           (stall),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .inst_valid      (inst_valid),
        .inst_data       (inst_data),
        .inst_pc         (inst_pc),
        .misalign_exc    (misalign_exc),
        .misalign_addr   (misalign_addr)
    );

    pc_fetch_sequencer #(
        .RESET_VEC (32'hFFFF_FFFC)
    ) dut_wrap (
        .clk             (clk),
        .rst_n           (rst_n),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .stall           (stall),
        .imem_req_valid  (req_valid1),
        .imem_req_addr   (req_addr1),
        .imem_req_ready  (imem_req_ready),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .inst_valid      (inst_valid1),
        .inst_data       (inst_data1),
        .inst_pc         (inst_pc1),
        .misalign_exc    (mexc1),
        .misalign_addr   (maddr1)
    );

    function automatic logic [31:0] dfun(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    // One clock: sample at negedge (log accepts, score consumed instructions), then drive the
    // memory model just after the rising edge.
    task automatic tick();
        bit          acc0, acc1;
        logic [31:0] a0, a1;
        exp_t        e;
        @(negedge clk);
        acc0 = imem_req_valid && imem_req_ready;
        acc1 = req_valid1 && imem_req_ready;
        a0   = imem_req_addr;
        a1   = req_addr1;
        if (acc0) acc_log.push_back(a0);
        if (acc1) acc_log1.push_back(a1);
        if (inst_valid && !stall) begin
            n_checks++;
            n_pop++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got inst_pc=%h inst_data=%h, none expected", inst_pc, inst_data);
            end else begin
                e = exp_q.pop_front();
                if (inst_pc !== e.pc || inst_data !== e.data) begin
                    n_fail++;
                    $display("FAIL sb_inst: got pc=%h data=%h, want pc=%h data=%h", inst_pc, inst_data, e.pc, e.data);
                end
            end
        end
        @(posedge clk);
        #1;
        imem_rsp_valid = 1'b0;
        if (acc0) begin
            pend      = 1'b1;
            pend_cnt  = mem_lat;
            pend_addr = a0;
        end
        if (pend) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                pend           = 1'b0;
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = dfun(pend_addr);
                if (drop_cnt > 0) begin
                    drop_cnt--;
                end else begin
                    e.pc   = pend_addr;
                    e.data = dfun(pend_addr);
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    task automatic do_reset(input bit release_rst);
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = '0;
        stall = 1'b0;
        imem_rsp_valid = 1'b0;
        pend = 1'b0;
        drop_cnt = 0;
        n_pop = 0;
        exp_q.delete();
        acc_log.delete();
        acc_log1.delete();
        repeat (2) tick();
        if (release_rst) rst_n = 1'b1;
    endtask

    task automatic wait_acc(input int n, input string tag);
        int k = 0;
        while (acc_log.size() < n && k < 60) begin
            tick();
            k++;
        end
        n_checks++;
        if (acc_log.size() < n) begin
            n_fail++;
            $display("FAIL %s_acc_timeout: got %0d accepted requests, want %0d", tag, acc_log.size(), n);
        end
    endtask

    task automatic wait_pop(input int n, input string tag);
        int k = 0;
        while (n_pop < n && k < 60) begin
            tick();
            k++;
        end
        n_checks++;
        if (n_pop < n) begin
            n_fail++;
            $display("FAIL %s_inst_timeout: got %0d instructions, want %0d", tag, n_pop, n);
        end
    endtask

    task automatic test_reset();
        imem_req_ready = 1'b0;
        do_reset(1'b0);
        n_checks += 7;
        if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_req_valid: got %b want 0", imem_req_valid); end
        if (imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL rst_req_addr: got %h want 0", imem_req_addr); end
        if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rst_inst_valid: got %b want 0", inst_valid); end
        if (inst_data !== 32'h0 || inst_pc !== 32'h0) begin n_fail++; $display("FAIL rst_inst: got data=%h pc=%h want 0", inst_data, inst_pc); end
        if (misalign_exc !== 1'b0) begin n_fail++; $display("FAIL rst_misalign_exc: got %b want 0", misalign_exc); end
        if (misalign_addr !== 32'h0) begin n_fail++; $display("FAIL rst_misalign_addr: got %h want 0", misalign_addr); end
        if (req_addr1 !== 32'h0 || req_valid1 !== 1'b0) begin n_fail++; $display("FAIL rst_wrap_req: got v=%b a=%h want 0", req_valid1, req_addr1); end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL boot_req_valid: got %b want 0", imem_req_valid); end
        tick();
        n_checks += 2;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL first_req: got v=%b a=%h want 1/00000000", imem_req_valid, imem_req_addr); end
        if (req_addr1 !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL first_req_wrap: got %h want fffffffc", req_addr1); end
    endtask

    task automatic test_sequential();
        logic [31:0] want;
        mem_lat = 1;
        imem_req_ready = 1'b1;
        do_reset(1'b1);
        wait_acc(3, "seq");
        for (int i = 0; i < 3; i++) begin
            want = 32'(i * 4);
            n_checks++;
            if (i >= acc_log.size() || acc_log[i] !== want) begin
                n_fail++;
                $display("FAIL seq_addr%0d: got %h want %h", i, (i < acc_log.size()) ? acc_log[i] : 32'hx, want);
            end
        end
        wait_pop(3, "seq");
    endtask

    task automatic test_ready_hold();
        mem_lat = 1;
        imem_req_ready = 1'b0;
        do_reset(1'b1);
        tick();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0 || inst_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL ready_hold%0d: got v=%b a=%h iv=%b want 1/00000000/0", i, imem_req_valid, imem_req_addr, inst_valid);
            end
            tick();
        end
        imem_req_ready = 1'b1;
        wait_pop(1, "ready_hold");
    endtask

    task automatic test_redirect_wait();
        mem_lat = 2;
        imem_req_ready = 1'b1;
        do_reset(1'b1);
        wait_acc(2, "redir_wait");
        redirect_valid = 1'b1;
        redirect_target = 32'h100;
        drop_cnt = 1;
        tick();
        redirect_valid = 1'b0;
        wait_acc(3, "redir_wait");
        n_checks++;
        if (acc_log.size() < 3 || acc_log[1] !== 32'h4 || acc_log[2] !== 32'h100) begin
            n_fail++;
            $display("FAIL redir_wait_addr: got %h,%h want 00000004,00000100",
                     (acc_log.size() > 1) ? acc_log[1] : 32'hx, (acc_log.size() > 2) ? acc_log[2] : 32'hx);
        end
        wait_pop(2, "redir_wait");
    endtask

    task automatic test_back_to_back();
        mem_lat = 1;
        imem_req_ready = 1'b1;
        do_reset(1'b1);
        tick();
        redirect_valid = 1'b1;
        redirect_target = 32'h200;
        drop_cnt = 1;
        tick();
        redirect_valid = 1'b0;
        wait_acc(2, "redir_req");
        n_checks++;
        if (acc_log.size() < 2 || acc_log[0] !== 32'h0 || acc_log[1] !== 32'h200) begin
            n_fail++;
            $display("FAIL redir_req_addr: got %h,%h want 00000000,00000200",
                     (acc_log.size() > 0) ? acc_log[0] : 32'hx, (acc_log.size() > 1) ? acc_log[1] : 32'hx);
        end
        wait_pop(1, "redir_req");
    endtask

    task automatic test_misalign();
        mem_lat = 1;
        imem_req_ready = 1'b1;
        do_reset(1'b1);
        wait_acc(1, "misalign");
        redirect_valid = 1'b1;
        redirect_target = 32'h102;
        tick();
        redirect_valid = 1'b0;
        n_checks++;
        if (misalign_exc !== 1'b1 || misalign_addr !== 32'h102) begin
            n_fail++;
            $display("FAIL misalign_pulse: got exc=%b addr=%h want 1/00000102", misalign_exc, misalign_addr);
        end
        tick();
        n_checks++;
        if (misalign_exc !== 1'b0) begin n_fail++; $display("FAIL misalign_width: got exc=%b want 0", misalign_exc); end
        wait_acc(3, "misalign");
        n_checks++;
        if (acc_log.size() < 3 || acc_log[1] !== 32'h4 || acc_log[2] !== 32'h8) begin
            n_fail++;
            $display("FAIL misalign_seq: got %h,%h want 00000004,00000008",
                     (acc_log.size() > 1) ? acc_log[1] : 32'hx, (acc_log.size() > 2) ? acc_log[2] : 32'hx);
        end
        wait_pop(2, "misalign");
    endtask

    task automatic test_stall();
        mem_lat = 1;
        imem_req_ready = 1'b1;
        do_reset(1'b1);
        wait_acc(3, "stall");
        stall = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (inst_valid !== 1'b1 || inst_pc !== 32'h8 || inst_data !== dfun(32'h8) || imem_req_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got iv=%b pc=%h data=%h rv=%b want 1/00000008/%h/0",
                         i, inst_valid, inst_pc, inst_data, imem_req_valid, dfun(32'h8));
            end
            tick();
        end
        n_checks++;
        if (acc_log.size() != 3) begin n_fail++; $display("FAIL stall_no_req: got %0d accepts want 3", acc_log.size()); end
        stall = 1'b0;
        wait_acc(4, "stall");
        n_checks++;
        if (acc_log.size() < 4 || acc_log[3] !== 32'hC) begin
            n_fail++;
            $display("FAIL stall_next: got %h want 0000000c", (acc_log.size() > 3) ? acc_log[3] : 32'hx);
        end
        wait_pop(4, "stall");
    endtask

    task automatic test_wrap_and_midreset();
        mem_lat = 1;
        imem_req_ready = 1'b1;
        do_reset(1'b1);
        wait_acc(2, "wrap");
        n_checks++;
        if (acc_log1.size() < 2 || acc_log1[0] !== 32'hFFFF_FFFC || acc_log1[1] !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap_addr: got %h,%h want fffffffc,00000000",
                     (acc_log1.size() > 0) ? acc_log1[0] : 32'hx, (acc_log1.size() > 1) ? acc_log1[1] : 32'hx);
        end
        // Reset while a request is outstanding and a previous instruction sits in the register.
        mem_lat = 2;
        do_reset(1'b1);
        wait_acc(3, "midrst");
        rst_n = 1'b0;
        #1;
        n_checks += 2;
        if (imem_req_valid !== 1'b0 || imem_req_addr !== 32'h0 || inst_valid !== 1'b0 || inst_data !== 32'h0 ||
            inst_pc !== 32'h0 || misalign_exc !== 1'b0 || misalign_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got rv=%b ra=%h iv=%b id=%h ip=%h me=%b ma=%h want all 0",
                     imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc, misalign_exc, misalign_addr);
        end
        if (req_valid1 !== 1'b0 || inst_pc1 !== 32'h0 || inst_data1 !== 32'h0) begin
            n_fail++;
            $display("FAIL midrst_wrap: got rv=%b ip=%h id=%h want 0", req_valid1, inst_pc1, inst_data1);
        end
        mem_lat = 1;
        do_reset(1'b1);
        // A stray response right after release must never reach decode.
        imem_rsp_valid = 1'b1;
        imem_rsp_data = 32'hBAD0_BAD0;
        tick();
        tick();
        n_checks++;
        if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL stray_rsp: got inst_valid=%b want 0", inst_valid); end
        wait_pop(1, "midrst");
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sequential();
        test_ready_hold();
        test_redirect_wait();
        test_back_to_back();
        test_misalign();
        test_stall();
        test_wrap_and_midreset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
